// File: rtl/fetch_ctrl_if.sv
// Bundle between the run controller and the fetch unit (PC + instruction ROM).
// master = fetch_ctrl side, slave = fetch unit side.
interface fetch_ctrl_if #(
  parameter int width  = 9,
  parameter int iwidth = 9
);
  logic              fu_start;
  logic [width-1:0]  fu_start_addr;
  logic              fu_branch;
  logic              fu_taken;
  logic [width-1:0]  fu_target;
  logic [width-1:0]  pc_in;
  logic [iwidth-1:0] instr_in;

  modport master (
    output fu_start, fu_start_addr, fu_branch, fu_taken, fu_target,
    input  pc_in, instr_in
  );

  modport slave (
    input  fu_start, fu_start_addr, fu_branch, fu_taken, fu_target,
    output pc_in, instr_in
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Run controller sequencing the fetch unit through launch, run and halt/timeout.
// Optional macro SINGLE_STEP_EN adds step_mode/step inputs for single stepping.
module fetch_ctrl #(
  parameter int                width      = 9,
  parameter int                iwidth     = 9,
  parameter logic [iwidth-1:0] HALT_INSTR = 9'h1FF,
  parameter int                CNT_W      = 16,
  parameter logic [CNT_W-1:0]  MAX_CYCLES = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  fetch_ctrl_if.master     fu,
  input  logic             req,
  input  logic [width-1:0] prog_addr,
  input  logic             stall_in,
  input  logic             dp_branch,
  input  logic             dp_taken,
  input  logic [width-1:0] dp_target,
`ifdef SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [width-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]   cycleCnt_q, cycleCnt_d;
  logic [CNT_W-1:0]   instrCnt_q, instrCnt_d;
  logic               timeout_q, timeout_d;

  logic holdRun;
  logic countEn;
  logic isHalt;
  logic haltNow;

  // A step-mode cycle without a step behaves exactly like a datapath stall.
`ifdef SINGLE_STEP_EN
  assign holdRun = stall_in | (step_mode & ~step);
  assign countEn = ~step_mode | step;
`else
  assign holdRun = stall_in;
  assign countEn = 1'b1;
`endif

  assign isHalt  = (fu.instr_in == HALT_INSTR);
  assign haltNow = ~holdRun & isHalt;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cycleCnt_d       = cycleCnt_q;
    instrCnt_d       = instrCnt_q;
    timeout_d        = timeout_q;
    fu.fu_start      = 1'b0;
    fu.fu_start_addr = addr_q;
    fu.fu_branch     = 1'b0;
    fu.fu_taken      = 1'b0;
    fu.fu_target     = '0;
    run_en           = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;

    unique case (state_q)
      IDLE: begin
        fu.fu_start = 1'b1;
        if (req) begin
          addr_d  = prog_addr;
          state_d = LOAD;
        end
      end

      LOAD: begin
        fu.fu_start = 1'b1;
        busy        = 1'b1;
        cycleCnt_d  = '0;
        instrCnt_d  = '0;
        timeout_d   = 1'b0;
        state_d     = RUN;
      end

      RUN: begin
        busy   = 1'b1;
        run_en = ~holdRun & ~isHalt;
        // Freezing the PC is done with a taken branch back to the current PC.
        if (holdRun || isHalt) begin
          fu.fu_branch = 1'b1;
          fu.fu_taken  = 1'b1;
          fu.fu_target = fu.pc_in;
        end else begin
          fu.fu_branch = dp_branch;
          fu.fu_taken  = dp_taken;
          fu.fu_target = dp_target;
          instrCnt_d   = instrCnt_q + 1'b1;
        end
        if (countEn) begin
          cycleCnt_d = cycleCnt_q + 1'b1;
        end
        if (haltNow) begin
          state_d = DONE;
        end else if (countEn && (cycleCnt_q == MAX_CYCLES - 1'b1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end

      DONE: begin
        done         = 1'b1;
        fu.fu_branch = 1'b1;
        fu.fu_taken  = 1'b1;
        fu.fu_target = fu.pc_in;
        if (req) begin
          addr_d  = prog_addr;
          state_d = LOAD;
        end
      end

      default: state_d = IDLE;
    endcase

    // While reset is held the fetch unit is pinned to a restart at address 0.
    if (reset) begin
      fu.fu_start      = 1'b1;
      fu.fu_start_addr = '0;
      fu.fu_branch     = 1'b0;
      fu.fu_taken      = 1'b0;
      fu.fu_target     = '0;
      run_en           = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cycleCnt_q <= '0;
      instrCnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cycleCnt_q <= cycleCnt_d;
      instrCnt_q <= instrCnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout   = timeout_q;
  assign cycle_cnt = cycleCnt_q;
  assign instr_cnt = instrCnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Run controller that sequences the fetch unit (program counter plus instruction ROM) for one program execution. It accepts a launch request with a program start address and loads the PC through the fetch unit's start/start_addr path. It then passes datapath branch requests through to the fetch unit. It freezes the PC during stalls and after halt or timeout, using a branch-to-self, and keeps cycle and instruction counters for the test harness.

Parameters:
width, 9, PC/address width (matches fetch unit)
iwidth, 9, instruction width
HALT_INSTR, 9'h1FF, instruction encoding that ends the program
CNT_W, 16, width of cycle/instruction counters
MAX_CYCLES, 16'hFFFF, watchdog limit in RUN cycles

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req  in  1  launch pulse; sampled in IDLE or DONE only
prog_addr  in  width  start address captured with req
pc_in  in  width  fetch unit pc_out
instr_in  in  iwidth  fetch unit instr_out
stall_in  in  1  datapath cannot accept instruction this cycle
dp_branch  in  1  datapath branch instruction
dp_taken  in  1  datapath branch resolved taken
dp_target  in  width  datapath branch target
fu_start  out  1  to fetch unit start
fu_start_addr  out  width  to fetch unit start_addr
fu_branch  out  1  to fetch unit branch
fu_taken  out  1  to fetch unit taken
fu_target  out  width  to fetch unit target
run_en  out  1  datapath may commit the current instruction
busy  out  1  state is LOAD or RUN
done  out  1  state is DONE
timeout  out  1  DONE was reached by the watchdog
cycle_cnt  out  CNT_W  RUN cycles since last launch
instr_cnt  out  CNT_W  committed instructions since last launch

Behaviour:
- States: IDLE, LOAD, RUN, DONE; 2-bit encoding, registered.
- Reset: state=IDLE, addr_q=0, cycle_cnt=0, instr_cnt=0, timeout=0. Reset applies at any time, including mid-RUN, and overrides req.
- Reset outputs: fu_start=1, fu_start_addr=0, fu_branch=0, fu_taken=0, fu_target=0, run_en=0, busy=0, done=0.
- IDLE: fu_start=1, fu_start_addr=addr_q. req=1 -> addr_q<=prog_addr, go to LOAD.
- LOAD (exactly 1 cycle): fu_start=1, fu_start_addr=addr_q (new value); clear both counters and timeout; go to RUN. The PC therefore equals prog_addr in the first RUN cycle, 2 cycles after req.
- RUN: fu_start=0, run_en = ~stall_in & (instr_in != HALT_INSTR).
  - If stall_in=1: hold the PC with fu_branch=1, fu_taken=1, fu_target=pc_in.
  - Else if instr_in==HALT_INSTR: hold the PC the same way, go to DONE, timeout stays 0. The halt instruction is not counted.
  - Else: fu_branch/fu_taken/fu_target = dp_branch/dp_taken/dp_target (combinational pass-through); instr_cnt+1.
  - cycle_cnt+1 every RUN cycle.
  - If cycle_cnt==MAX_CYCLES-1 and no halt this cycle: go to DONE with timeout<=1. Halt has priority over timeout in the same cycle.
- DONE: PC held (self-branch), fu_start=0, done=1. Counters and timeout hold their values. req=1 -> capture prog_addr, go to LOAD.
- req is ignored in LOAD and RUN.
- Counters wrap modulo 2^CNT_W. MAX_CYCLES must be at most 2^CNT_W-1, so cycle_cnt cannot wrap in practice.
- All outputs are combinational from state plus the inputs listed above. There is no combinational path from req to any fu_* output.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds inputs step_mode (1) and step (1).
  - In RUN with step_mode=1, the block treats the cycle as stalled (PC self-branch, run_en=0, no instr_cnt increment) unless step=1 and stall_in=0.
  - Halt detection and the watchdog still apply. cycle_cnt counts only cycles where step_mode=0 or step=1.
  - step_mode=0 gives identical behaviour to the macro-undefined build.
- Undefined: ports absent; behaviour exactly as in Behaviour.

Test Plan:
- Reset held 3 cycles, release -> fu_start=1, fu_start_addr=0, busy=0, done=0, counters 0.
- req with prog_addr=9'h010 in IDLE, ROM of 5 non-halt instructions then HALT_INSTR, no stalls:
  - LOAD one cycle after req; RUN from cycle 2 with pc_in=9'h010.
  - done=1 after 6 RUN cycles, with instr_cnt=5, cycle_cnt=6, timeout=0.
  - pc_in stays fixed at the halt address while in DONE.
- stall_in=1 for 3 cycles mid-program -> pc_in unchanged across the stall, run_en=0; instr_cnt is 3 lower than cycle_cnt at halt.
- Taken branch: dp_branch=1, dp_taken=1, dp_target=9'h020 in RUN -> next cycle pc_in=9'h020. The same branch with stall_in=1 is ignored.
- Watchdog: MAX_CYCLES=16, program loops via self-branch -> DONE after 16 RUN cycles with timeout=1. A new req then clears timeout in LOAD.
- reset asserted mid-RUN together with req -> IDLE next cycle, counters 0, fu_start=1; req is ignored.
